// File: rtl/mult_share_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mult_share_sched
//  Description : Round-robin scheduler that shares one sequential shift-add
//                multiplier among N_REQ requesters. It accepts one operand
//                pair at a time, pulses the multiplier Start, follows the
//                Ready fall/rise handshake, captures the 2*DP_W product and
//                returns it tagged with the requester ID. A watchdog aborts
//                a job that never completes and returns an error response.
//  Ports       :
//    clock            in   rising-edge system clock
//    reset            in   asynchronous active-high reset
//    req              in   per-requester request level
//    req_a / req_b    in   packed operands, slice i = [i*DP_W +: DP_W]
//    gnt              out  one-hot, one-cycle accept pulse
//    rsp_valid        out  one-cycle result strobe
//    rsp_id           out  requester index of the result
//    rsp_product      out  2*DP_W product (0 on error)
//    rsp_err          out  with rsp_valid: watchdog abort
//    busy             out  scheduler not idle
//    mul_start        out  multiplier Start
//    mul_multiplicand out  latched multiplicand
//    mul_multiplier   out  latched multiplier
//    mul_ready        in   multiplier Ready
//    mul_product      in   multiplier Product
//  Revision    : 1.0  initial release
// ============================================================================
module mult_share_sched #(
   parameter int N_REQ   = 4,
   parameter int ID_W    = 2,
   parameter int DP_W    = 5,
   parameter int TMO_CYC = 64
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req,
   input  logic [N_REQ*DP_W-1:0] req_a,
   input  logic [N_REQ*DP_W-1:0] req_b,
   output logic [N_REQ-1:0]      gnt,
   output logic                  rsp_valid,
   output logic [ID_W-1:0]       rsp_id,
   output logic [2*DP_W-1:0]     rsp_product,
   output logic                  rsp_err,
   output logic                  busy,
   output logic                  mul_start,
   output logic [DP_W-1:0]       mul_multiplicand,
   output logic [DP_W-1:0]       mul_multiplier,
   input  logic                  mul_ready,
   input  logic [2*DP_W-1:0]     mul_product
);

   localparam int WD_W = $clog2(TMO_CYC + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TMO_CYC - 1);

   localparam logic [3:0] S_IDLE    = 4'b0001;
   localparam logic [3:0] S_ISSUE   = 4'b0010;
   localparam logic [3:0] S_WAIT_LO = 4'b0100;
   localparam logic [3:0] S_WAIT_HI = 4'b1000;

   logic [3:0]      state;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] id_lat;
   logic [DP_W-1:0] a_lat;
   logic [DP_W-1:0] b_lat;
   logic [WD_W-1:0] wdog;

   logic [DP_W-1:0] a_arr [N_REQ];
   logic [DP_W-1:0] b_arr [N_REQ];

   logic            win_found;
   logic [ID_W-1:0] win_id;
   logic [ID_W-1:0] cand;

   generate
      for (genvar i = 0; i < N_REQ; i++) begin : g_slice
         assign a_arr[i] = req_a[i*DP_W +: DP_W];
         assign b_arr[i] = req_b[i*DP_W +: DP_W];
      end
   endgenerate

   // Search starts just after the last winner and wraps, so the last winner
   // is considered last; this bounds the wait of any held request.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = ID_W'((int'(ptr) + k) % N_REQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
   end

   assign busy             = (state != S_IDLE);
   assign mul_start        = (state == S_ISSUE);
   assign mul_multiplicand = a_lat;
   assign mul_multiplier   = b_lat;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         ptr         <= ID_W'(N_REQ - 1);
         id_lat      <= '0;
         a_lat       <= '0;
         b_lat       <= '0;
         wdog        <= '0;
         gnt         <= '0;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_id      <= '0;
         rsp_product <= '0;
      end else begin
         // gnt and the response strobe are single-cycle pulses.
         gnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         case (state)
            S_IDLE: begin
               // A busy multiplier (Ready low) blocks acceptance entirely.
               if (win_found && mul_ready) begin
                  a_lat  <= a_arr[win_id];
                  b_lat  <= b_arr[win_id];
                  id_lat <= win_id;
                  gnt    <= N_REQ'(1) << win_id;
                  ptr    <= win_id;
                  state  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               wdog  <= '0;
               state <= S_WAIT_LO;
            end
            S_WAIT_LO: begin
               wdog <= wdog + 1'b1;
               if (!mul_ready) begin
                  state <= S_WAIT_HI;
               end else if (wdog == WD_LAST) begin
                  rsp_valid   <= 1'b1;
                  rsp_err     <= 1'b1;
                  rsp_product <= '0;
                  rsp_id      <= id_lat;
                  state       <= S_IDLE;
               end
            end
            S_WAIT_HI: begin
               wdog <= wdog + 1'b1;
               // Product is only guaranteed in the first Ready-high cycle.
               if (mul_ready) begin
                  rsp_valid   <= 1'b1;
                  rsp_err     <= 1'b0;
                  rsp_product <= mul_product;
                  rsp_id      <= id_lat;
                  state       <= S_IDLE;
               end else if (wdog == WD_LAST) begin
                  rsp_valid   <= 1'b1;
                  rsp_err     <= 1'b1;
                  rsp_product <= '0;
                  rsp_id      <= id_lat;
                  state       <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
